// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// zero register and write bypass, plus a per-register busy scoreboard for RAW stalls.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic                  use_rs,
  input  logic                  use_rt,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  hazard,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_en;
  logic                  set_en;
  logic                  inc;
  logic                  dec;
  logic                  fwd_rs;
  logic                  fwd_rt;

  // Writes and issues aimed at the hardwired zero register are dropped entirely.
  always_comb begin
    wr_en  = reg_write   && !(ZERO_REG && (rd == '0));
    set_en = issue_valid && !(ZERO_REG && (issue_rd == '0));
    fwd_rs = BYPASS && wr_en && (rd == rs);
    fwd_rt = BYPASS && wr_en && (rd == rt);
  end

  // NOTE: the storage array is built from resettable flops, not RAM, because an
  // asynchronous clear of every entry is required; it cannot map to a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking assignment for all sequential state, so every flop
      // samples pre-edge values regardless of process ordering.
      regs[rd] <= write_data;
    end
  end

  // Outputs are forced low while reset is held so a bypassed write cannot leak out.
  always_comb begin
    read_data1 = '0;
    if (!reset && !(ZERO_REG && (rs == '0)))
      read_data1 = fwd_rs ? write_data : regs[rs];
  end

  always_comb begin
    read_data2 = '0;
    if (!reset && !(ZERO_REG && (rt == '0)))
      read_data2 = fwd_rt ? write_data : regs[rt];
  end

  // Clear is applied before set so that a same-cycle set on the same register wins.
  always_comb begin
    busy_next = busy;
    if (wr_en)  busy_next[rd]       = 1'b0;
    if (set_en) busy_next[issue_rd] = 1'b1;
    inc        = set_en && !busy[issue_rd];
    dec        = wr_en && busy[rd] && !(set_en && (issue_rd == rd));
    count_next = busy_count + (ADDR_WIDTH + 1)'(inc) - (ADDR_WIDTH + 1)'(dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (!reset)
      hazard = (use_rs && busy[rs] && !fwd_rs) || (use_rt && busy[rt] && !fwd_rt);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing instance and one
// non-bypassing instance share all inputs; expectations are hand-computed.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, rd, issue_rd;
  logic        use_rs, use_rt, reg_write, issue_valid;
  logic [31:0] write_data;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        haz, nb_haz;
  logic [5:0]  cnt, nb_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .read_data1(rd1), .read_data2(rd2), .rd(rd), .write_data(write_data),
    .reg_write(reg_write), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .hazard(haz), .busy_count(cnt)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .read_data1(nb_rd1), .read_data2(nb_rd2), .rd(rd), .write_data(write_data),
    .reg_write(reg_write), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .hazard(nb_haz), .busy_count(nb_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rs = '0; rt = '0; rd = '0; issue_rd = '0;
    use_rs = 1'b0; use_rt = 1'b0; reg_write = 1'b0; issue_valid = 1'b0;
    write_data = '0;
    #12;
    check("reset_rd1", rd1, 32'h0);
    check("reset_haz", {31'b0, haz}, 32'h0);
    check("reset_cnt", {26'b0, cnt}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1. every address reads zero after reset
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(i);
      #1;
      check($sformatf("init_rd1_%0d", i), rd1, 32'h0);
      check($sformatf("init_rd2_%0d", i), rd2, 32'h0);
    end
    check("init_haz", {31'b0, haz}, 32'h0);
    check("init_cnt", {26'b0, cnt}, 32'h0);

    // 2. plain write/readback, and writes to r0 are ignored
    rd = 5'd5; write_data = 32'hDEADBEEF; reg_write = 1'b1;
    tick();
    reg_write = 1'b0; rs = 5'd5;
    #1;
    check("wr_r5", rd1, 32'hDEADBEEF);
    check("wr_r5_nb", nb_rd1, 32'hDEADBEEF);
    rd = 5'd0; write_data = 32'h1234; reg_write = 1'b1; rs = 5'd0;
    #1;
    check("r0_bypass", rd1, 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("r0_after", rd1, 32'h0);
    check("r0_after_nb", nb_rd1, 32'h0);

    // 3. same-cycle bypass versus old value
    rd = 5'd7; write_data = 32'h11111111; reg_write = 1'b1;
    tick();
    write_data = 32'hA5A5A5A5; rs = 5'd7; rt = 5'd7;
    #1;
    check("byp_rd1", rd1, 32'hA5A5A5A5);
    check("byp_rd2", rd2, 32'hA5A5A5A5);
    check("nobyp_rd1", nb_rd1, 32'h11111111);
    check("nobyp_rd2", nb_rd2, 32'h11111111);
    tick();
    reg_write = 1'b0;
    #1;
    check("nobyp_after", nb_rd1, 32'hA5A5A5A5);

    // 4. issue r3, r4; hazard and writeback
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    check("cnt_one", {26'b0, cnt}, 32'd1);
    issue_rd = 5'd4;
    tick();
    issue_valid = 1'b0;
    #1;
    check("cnt_two", {26'b0, cnt}, 32'd2);
    rs = 5'd3; use_rs = 1'b1; rt = 5'd0;
    #1;
    check("haz_r3", {31'b0, haz}, 32'd1);
    check("haz_r3_nb", {31'b0, nb_haz}, 32'd1);
    rd = 5'd3; write_data = 32'h33; reg_write = 1'b1;
    #1;
    check("haz_fwd", {31'b0, haz}, 32'd0);
    check("haz_nofwd_nb", {31'b0, nb_haz}, 32'd1);
    tick();
    reg_write = 1'b0;
    #1;
    check("cnt_after_wb", {26'b0, cnt}, 32'd1);
    check("haz_after_wb_nb", {31'b0, nb_haz}, 32'd0);
    rs = 5'd4; use_rs = 1'b0; rt = 5'd4; use_rt = 1'b1;
    #1;
    check("haz_rt_r4", {31'b0, haz}, 32'd1);
    use_rt = 1'b0;
    #1;
    check("haz_unused", {31'b0, haz}, 32'd0);

    // 5. set-wins collision, and set/clear of different registers
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    check("cnt_r9", {26'b0, cnt}, 32'd2);
    rd = 5'd9; write_data = 32'h99; reg_write = 1'b1;
    tick();
    issue_valid = 1'b0; reg_write = 1'b0; rs = 5'd9; use_rs = 1'b1;
    #1;
    check("cnt_collide", {26'b0, cnt}, 32'd2);
    check("haz_r9_busy", {31'b0, haz}, 32'd1);
    issue_valid = 1'b1; issue_rd = 5'd10; rd = 5'd4; write_data = 32'h44; reg_write = 1'b1;
    tick();
    issue_valid = 1'b0; reg_write = 1'b0; rs = 5'd4;
    #1;
    check("cnt_swap", {26'b0, cnt}, 32'd2);
    check("haz_r4_free", {31'b0, haz}, 32'd0);
    rs = 5'd10;
    #1;
    check("haz_r10", {31'b0, haz}, 32'd1);
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    check("cnt_issue_r0", {26'b0, cnt}, 32'd2);
    issue_rd = 5'd11;
    tick();
    issue_valid = 1'b0;
    #1;
    check("cnt_three", {26'b0, cnt}, 32'd3);
    issue_valid = 1'b1; issue_rd = 5'd11;
    tick();
    issue_valid = 1'b0;
    #1;
    check("cnt_reissue", {26'b0, cnt}, 32'd3);

    // 6. asynchronous reset between edges
    rs = 5'd5; rt = 5'd9; use_rt = 1'b1;
    #1;
    check("pre_rst_rd1", rd1, 32'hDEADBEEF);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cnt", {26'b0, cnt}, 32'd0);
    check("mid_rst_haz", {31'b0, haz}, 32'd0);
    check("mid_rst_rd1", rd1, 32'h0);
    check("mid_rst_rd2_nb", nb_rd2, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_r5", rd1, 32'h0);
    check("post_rst_haz", {31'b0, haz}, 32'd0);
    check("post_rst_cnt_nb", {26'b0, nb_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
